m_xy_lane_echo: RTL and testbench



---
 rtl/m_xy_lane_echo.sv | 119 +++++++++++
 tb/tb_m_xy_lane_echo.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/m_xy_lane_echo.sv
// Registered 8-lane x->y echo with per-lane saturating event counters and run/freeze/clear control.
// Optional parity tracking is built when M_XY_LANE_PARITY_EN is defined.
module m_xy_lane_echo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 8,
   parameter int unsigned SEL_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y,
   input  logic             freeze,
   input  logic             clr,
   input  logic [SEL_W-1:0] rd_sel,
   output logic [CNT_W-1:0] rd_cnt,
   output logic             rd_sat,
   output logic             busy
`ifdef M_XY_LANE_PARITY_EN
   ,
   input  logic             x_par,
   output logic             y_par,
   output logic             par_err
`endif
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      FROZEN = 2'd1,
      CLEAR  = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic             cnt_en;
   logic             cnt_zero;
   logic [CNT_W-1:0] cnt_q [WIDTH];

   // Next-state and counter control
   always_comb begin
      state_d  = state_q;
      cnt_en   = 1'b0;
      cnt_zero = 1'b0;
      case (state_q)
         RUN: begin
            if (clr)         state_d = CLEAR;
            else if (freeze) state_d = FROZEN;
         end
         FROZEN: begin
            if (clr)          state_d = CLEAR;
            else if (!freeze) state_d = RUN;
         end
         CLEAR: begin
            if (clr)         state_d = CLEAR;
            else if (freeze) state_d = FROZEN;
            else             state_d = RUN;
         end
         default: state_d = RUN;
      endcase
      // Counting resumes/stops in the same cycle freeze is sampled; clear always wins.
      cnt_en   = (state_q != CLEAR) && !freeze && !clr;
      cnt_zero = clr || (state_q == CLEAR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         busy    <= (state_d == CLEAR);
      end
   end

   // Echo path, independent of control state
   always_ff @(posedge clk) begin
      if (rst) y <= '0;
      else     y <= x;
   end

   // Per-lane saturating counters
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (rst || cnt_zero) begin
            cnt_q[i] <= '0;
         end else if (cnt_en && x[i] && (cnt_q[i] != '1)) begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // Readback reflects counter values before this edge's update
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_cnt <= '0;
         rd_sat <= 1'b0;
      end else if (32'(rd_sel) < WIDTH) begin
         rd_cnt <= cnt_q[rd_sel];
         rd_sat <= (cnt_q[rd_sel] == '1);
      end else begin
         rd_cnt <= '0;
         rd_sat <= 1'b0;
      end
   end

`ifdef M_XY_LANE_PARITY_EN
   // Parity of y travels with y; par_err is sticky until rst or clr
   always_ff @(posedge clk) begin
      if (rst) begin
         y_par   <= 1'b0;
         par_err <= 1'b0;
      end else begin
         y_par <= ^x;
         if (clr) par_err <= 1'b0;
         else     par_err <= par_err | (x_par != (^x));
      end
   end
`endif

endmodule

// File: tb/tb_m_xy_lane_echo.sv
// Self-checking bench for m_xy_lane_echo: directed steps plus random traffic against a lane-count model.
// Parity checks are included when M_XY_LANE_PARITY_EN is defined.
module tb_m_xy_lane_echo;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned SEL_W = 3;
   localparam int          CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             freeze;
   logic             clr;
   logic [SEL_W-1:0] rd_sel;
   logic [CNT_W-1:0] rd_cnt;
   logic             rd_sat;
   logic             busy;
`ifdef M_XY_LANE_PARITY_EN
   logic             x_par;
   logic             y_par;
   logic             par_err;
`endif

   m_xy_lane_echo #(.WIDTH(WIDTH), .CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
      .clk    (clk),
      .rst    (rst),
      .x      (x),
      .y      (y),
      .freeze (freeze),
      .clr    (clr),
      .rd_sel (rd_sel),
      .rd_cnt (rd_cnt),
      .rd_sat (rd_sat),
      .busy   (busy)
`ifdef M_XY_LANE_PARITY_EN
      ,
      .x_par  (x_par),
      .y_par  (y_par),
      .par_err(par_err)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference state: lane event counts, plus "was clr seen last edge" for busy / no-count
   int         m_cnt [WIDTH];
   logic       m_in_clear;
   logic [7:0] e_y;
   int         e_rd;
   logic       e_busy;
   logic       e_ypar;
   logic       e_perr;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance model, check all outputs 1ns after the edge
   task automatic step(input logic [7:0] xv, input logic fz, input logic cl,
                       input logic r, input logic [2:0] sel, input logic xp);
      x = xv; freeze = fz; clr = cl; rst = r; rd_sel = sel;
`ifdef M_XY_LANE_PARITY_EN
      x_par = xp;
`endif
      @(posedge clk);
      e_rd = (int'(sel) < int'(WIDTH)) ? m_cnt[sel] : 0;
      if (r) begin
         foreach (m_cnt[i]) m_cnt[i] = 0;
         m_in_clear = 1'b0;
         e_y = 8'h00; e_rd = 0; e_busy = 1'b0; e_ypar = 1'b0; e_perr = 1'b0;
      end else begin
         if (cl) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
         end else if (!m_in_clear && !fz) begin
            foreach (m_cnt[i]) if (xv[i] && m_cnt[i] < CMAX) m_cnt[i]++;
         end
         m_in_clear = cl;
         e_busy = cl;
         e_y    = xv;
         e_ypar = ^xv;
         e_perr = cl ? 1'b0 : (e_perr | (xp != (^xv)));
      end
      #1;
      chk("y", int'(y), int'(e_y));
      chk("busy", int'(busy), int'(e_busy));
      chk("rd_cnt", int'(rd_cnt), e_rd);
      chk("rd_sat", int'(rd_sat), int'(e_rd == CMAX));
`ifdef M_XY_LANE_PARITY_EN
      chk("y_par", int'(y_par), int'(e_ypar));
      chk("par_err", int'(par_err), int'(e_perr));
`endif
   endtask

   initial begin
      logic [7:0] rx;
      logic       rfz, rcl, rr, rxp;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_in_clear = 1'b0; e_perr = 1'b0; e_ypar = 1'b0;
      x = '0; freeze = 1'b0; clr = 1'b0; rst = 1'b1; rd_sel = '0;
`ifdef M_XY_LANE_PARITY_EN
      x_par = 1'b0;
`endif

      // Reset state
      step(8'h00, 0, 0, 1, 3'd0, 0);
      step(8'h00, 0, 0, 1, 3'd0, 0);
      chk("reset_y", int'(y), 0);
      chk("reset_busy", int'(busy), 0);

      // Walking one, then read every lane back
      for (int i = 0; i < 8; i++) begin
         rx = 8'h01 << i;
         step(rx, 0, 0, 0, 3'd0, ^rx);
         chk("walk_y", int'(y), int'(rx));
      end
      for (int i = 0; i < 9; i++) begin
         step(8'h00, 0, 0, 0, 3'(i), 0);
         if (i > 0) chk("walk_cnt", int'(rd_cnt), 1);
      end

      // Lane hold and saturation
      step(8'h00, 0, 0, 1, 3'd3, 0);
      for (int i = 0; i < 20; i++) step(8'h08, 0, 0, 0, 3'd3, 1);
      step(8'h00, 0, 0, 0, 3'd3, 0);
      chk("sat_cnt", int'(rd_cnt), CMAX);
      chk("sat_flag", int'(rd_sat), 1);

      // Freeze: 5 counted, 5 frozen, 2 counted
      step(8'h00, 0, 0, 1, 3'd0, 0);
      for (int i = 0; i < 5; i++) step(8'hFF, 0, 0, 0, 3'd0, 0);
      for (int i = 0; i < 5; i++) step(8'hFF, 1, 0, 0, 3'd0, 0);
      for (int i = 0; i < 2; i++) step(8'hFF, 0, 0, 0, 3'd0, 0);
      for (int i = 0; i < 9; i++) begin
         step(8'h00, 0, 0, 0, 3'(i), 0);
         if (i > 0) chk("frz_cnt", int'(rd_cnt), 7);
      end

      // Clear with freeze in the same cycle: clear wins, busy for one cycle
      step(8'hAA, 1, 1, 0, 3'd1, 0);
      chk("clr_busy", int'(busy), 1);
      chk("clr_y", int'(y), 8'hAA);
      step(8'hFF, 1, 0, 0, 3'd1, 0);
      chk("clr_busy_drop", int'(busy), 0);
      step(8'hFF, 1, 0, 0, 3'd1, 0);
      chk("clr_cnt", int'(rd_cnt), 0);
      step(8'hFF, 0, 0, 0, 3'd1, 0);
      step(8'h00, 0, 0, 0, 3'd1, 0);
      chk("clr_resume", int'(rd_cnt), 1);

      // Reset mid-run drops the pending x
      step(8'h5A, 0, 0, 0, 3'd1, 0);
      step(8'h5A, 0, 0, 1, 3'd1, 0);
      chk("rst_y", int'(y), 0);
      step(8'h5A, 0, 0, 0, 3'd1, 0);
      chk("rst_cnt", int'(rd_cnt), 0);
      step(8'h00, 0, 0, 0, 3'd1, 0);
      chk("post_rst_y", int'(y), 8'h00);

`ifdef M_XY_LANE_PARITY_EN
      // Parity mismatch is sticky until clr
      step(8'h07, 0, 0, 0, 3'd0, 0);
      chk("par_set", int'(par_err), 1);
      chk("par_y", int'(y_par), 1);
      step(8'h00, 0, 0, 0, 3'd0, 0);
      chk("par_hold", int'(par_err), 1);
      step(8'h00, 0, 1, 0, 3'd0, 0);
      chk("par_clr", int'(par_err), 0);
`endif

      // Random traffic against the model
      for (int n = 0; n < 600; n++) begin
         rx  = 8'($urandom) & 8'($urandom);
         rfz = ($urandom_range(7) == 0);
         rcl = ($urandom_range(24) == 0);
         rr  = ($urandom_range(99) == 0);
         rxp = ($urandom_range(15) == 0) ? ~(^rx) : (^rx);
         step(rx, rfz, rcl, rr, 3'($urandom_range(7)), rxp);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
